// File: rtl/store_buffer_merge_pkg.sv
// Shared types and helpers for the LSU store buffer.
// Access-size encoding and the byte-lane merge used when coalescing stores.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } sb_size_e;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Lanes with be set take the new byte, all others keep the old byte.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_data,
    input logic [MAX_DATA_W-1:0] new_data,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    for (int i = 0; i < MAX_BE_W; i++) begin
      res[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_merge_sb_queue.sv
// Circular queue with occupancy count, flush, and an in-place tail rewrite port.
// Entries and valid bits are exported whole so the owner can scan them.
module sb_queue
  import store_buffer_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  W     = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [W-1:0]            push_data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic                    tail_wr_i,
  input  logic [W-1:0]            tail_data_i,
  output logic [DEPTH-1:0][W-1:0] mem_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic [PW-1:0]           rptr_o,
  output logic [PW-1:0]           wptr_o,
  output logic [PW:0]             cnt_o
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [DEPTH-1:0]        valid;
  logic [PW-1:0]           rptr, wptr;
  logic [PW:0]             cnt;

  // Flush discards everything between rptr and wptr and wins over push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
      rptr  <= '0;
      wptr  <= '0;
      cnt   <= '0;
    end else if (flush_i) begin
      valid <= '0;
      wptr  <= rptr;
      cnt   <= '0;
    end else begin
      if (pop_i) begin
        valid[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      if (push_i) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset: valid bits qualify every read.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem[wptr] <= push_data_i;
    end else if (tail_wr_i) begin
      mem[wptr - 1'b1] <= tail_data_i;
    end
  end

  assign mem_o   = mem;
  assign valid_o = valid;
  assign rptr_o  = rptr;
  assign wptr_o  = wptr;
  assign cnt_o   = cnt;

endmodule

// File: rtl/store_buffer_merge.sv
// LSU store buffer: speculative queue -> commit queue -> D$ write port, plus load page-offset hazard.
// Define STORE_BUF_MERGE_EN to coalesce commits into the commit-queue tail when they hit the same data word.
module store_buffer_merge
  import store_buffer_pkg::*;
#(
  parameter int PLEN         = 56,
  parameter int DATA_W       = 64,
  parameter int DEPTH_SPEC   = 4,
  parameter int DEPTH_COMMIT = 8,
  parameter int OFFSET_W     = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          stall_st_pending_i,
  input  logic                          valid_i,
  input  logic                          valid_without_flush_i,
  input  logic [PLEN-1:0]               paddr_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic [DATA_W/8-1:0]           be_i,
  input  logic [1:0]                    data_size_i,
  output logic                          ready_o,
  input  logic                          commit_i,
  output logic                          commit_ready_o,
  input  logic [OFFSET_W-1:0]           page_offset_i,
  output logic                          page_offset_matches_o,
  output logic                          no_st_pending_o,
  output logic                          store_buffer_empty_o,
  output logic [$clog2(DEPTH_SPEC):0]   spec_cnt_o,
  output logic [$clog2(DEPTH_COMMIT):0] commit_cnt_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [PLEN-1:0]               mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_be_o,
  output logic [1:0]                    mem_size_o
);

  localparam int BE_W = DATA_W / 8;
  localparam int BO   = $clog2(BE_W);
  localparam int SPW  = $clog2(DEPTH_SPEC);
  localparam int CPW  = $clog2(DEPTH_COMMIT);
  localparam logic [SPW:0] SPEC_LIM  = (SPW+1)'(DEPTH_SPEC - 1);
  localparam logic [SPW:0] SPEC_FULL = (SPW+1)'(DEPTH_SPEC);
  localparam logic [CPW:0] CQ_FULL   = (CPW+1)'(DEPTH_COMMIT);

  typedef struct packed {
    logic [PLEN-1:0]   addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    sb_size_e          size;
  } sb_entry_t;

  localparam int EW = $bits(sb_entry_t);

  sb_entry_t                    push_ent, spec_head, cq_head, merged_ent;
  sb_entry_t [DEPTH_SPEC-1:0]   spec_ent;
  sb_entry_t [DEPTH_COMMIT-1:0] cq_ent;
  logic [DEPTH_SPEC-1:0]        spec_valid;
  logic [DEPTH_COMMIT-1:0]      cq_valid;
  logic [SPW-1:0]               spec_rptr, spec_wptr;
  logic [CPW-1:0]               cq_rptr, cq_wptr;
  logic [SPW:0]                 spec_cnt;
  logic [CPW:0]                 cq_cnt;
  logic                         merge, cq_push, cq_pop;

  assign push_ent = '{addr: paddr_i, data: data_i, be: be_i, size: sb_size_e'(data_size_i)};

  sb_queue #(.DEPTH(DEPTH_SPEC), .W(EW)) u_spec_q (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (valid_i),
    .push_data_i(push_ent),
    .pop_i      (commit_i),
    .flush_i    (flush_i),
    .tail_wr_i  (1'b0),
    .tail_data_i({EW{1'b0}}),
    .mem_o      (spec_ent),
    .valid_o    (spec_valid),
    .rptr_o     (spec_rptr),
    .wptr_o     (spec_wptr),
    .cnt_o      (spec_cnt)
  );

  assign spec_head = spec_ent[spec_rptr];
  assign cq_head   = cq_ent[cq_rptr];
  assign cq_push   = commit_i && !merge;
  assign cq_pop    = mem_req_o && mem_gnt_i;

`ifdef STORE_BUF_MERGE_EN
  logic [CPW-1:0]        cq_tail_idx;
  logic [MAX_DATA_W-1:0] merged_data;

  // The head cannot be rewritten while it is being offered to the D$.
  assign cq_tail_idx = cq_wptr - 1'b1;
  assign merge = commit_i && (cq_cnt != '0) && cq_valid[cq_tail_idx]
              && (cq_ent[cq_tail_idx].addr[PLEN-1:BO] == spec_head.addr[PLEN-1:BO])
              && !((cq_tail_idx == cq_rptr) && mem_req_o);
  assign merged_data = merge_bytes(MAX_DATA_W'(cq_ent[cq_tail_idx].data),
                                   MAX_DATA_W'(spec_head.data),
                                   MAX_BE_W'(spec_head.be));

  always_comb begin
    merged_ent                = cq_ent[cq_tail_idx];
    merged_ent.data           = merged_data[DATA_W-1:0];
    merged_ent.be             = merged_ent.be | spec_head.be;
    merged_ent.size           = sb_size_e'(BO);
    merged_ent.addr[BO-1:0]   = '0;
  end
`else
  assign merge      = 1'b0;
  assign merged_ent = '0;
`endif

  sb_queue #(.DEPTH(DEPTH_COMMIT), .W(EW)) u_commit_q (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (cq_push),
    .push_data_i(spec_head),
    .pop_i      (cq_pop),
    .flush_i    (1'b0),
    .tail_wr_i  (merge),
    .tail_data_i(merged_ent),
    .mem_o      (cq_ent),
    .valid_o    (cq_valid),
    .rptr_o     (cq_rptr),
    .wptr_o     (cq_wptr),
    .cnt_o      (cq_cnt)
  );

  // Handshakes: valid_i is only legal while ready_o is high; mem_req_o keeps the
  // head fields stable until mem_gnt_i, and req&gnt in one cycle retires the head.
  assign ready_o              = (spec_cnt < SPEC_LIM) || commit_i;
  assign commit_ready_o       = (cq_cnt != CQ_FULL);
  assign no_st_pending_o      = (cq_cnt == '0);
  assign store_buffer_empty_o = (cq_cnt == '0) && (spec_cnt == '0);
  assign spec_cnt_o           = spec_cnt;
  assign commit_cnt_o         = cq_cnt;
  assign mem_req_o            = cq_valid[cq_rptr] && !stall_st_pending_i;
  assign mem_addr_o           = cq_head.addr;
  assign mem_wdata_o          = cq_head.data;
  assign mem_be_o             = cq_head.be;
  assign mem_size_o           = cq_head.size;

  always_comb begin
    page_offset_matches_o = valid_without_flush_i
                         && (paddr_i[OFFSET_W-1:BO] == page_offset_i[OFFSET_W-1:BO]);
    for (int i = 0; i < DEPTH_SPEC; i++) begin
      if (spec_valid[i] && (spec_ent[i].addr[OFFSET_W-1:BO] == page_offset_i[OFFSET_W-1:BO]))
        page_offset_matches_o = 1'b1;
    end
    for (int i = 0; i < DEPTH_COMMIT; i++) begin
      if (cq_valid[i] && (cq_ent[i].addr[OFFSET_W-1:BO] == page_offset_i[OFFSET_W-1:BO]))
        page_offset_matches_o = 1'b1;
    end
  end

  a_commit_flush: assert property (@(posedge clk_i) disable iff (rst_i) !(commit_i && flush_i));
  a_push_full:    assert property (@(posedge clk_i) disable iff (rst_i)
                    !(valid_i && !flush_i && !commit_i && (spec_cnt == SPEC_FULL)));
  a_commit_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(commit_i && (spec_cnt == '0)));
  a_commit_full:  assert property (@(posedge clk_i) disable iff (rst_i)
                    !(cq_push && !cq_pop && (cq_cnt == CQ_FULL)));
  a_spec_ptrs:    assert property (@(posedge clk_i) disable iff (rst_i)
                    (spec_cnt == '0) |-> (spec_rptr == spec_wptr));
  a_cq_ptrs:      assert property (@(posedge clk_i) disable iff (rst_i)
                    (cq_cnt == '0) |-> (cq_rptr == cq_wptr));

endmodule

// File: tb/tb_store_buffer_merge.sv
// Directed bench for store_buffer_merge: reset, drain ordering, flush, hazard, merge and reset mid-drain.
// Merge expectations follow STORE_BUF_MERGE_EN when the bench is built with it.
module tb_store_buffer_merge;

  logic        clk, rst;
  logic        flush, stall, valid, valid_wf, commit, gnt;
  logic [55:0] paddr;
  logic [63:0] data;
  logic [7:0]  be;
  logic [1:0]  size;
  logic [11:0] page_offset;
  logic        ready, commit_ready, match, no_st_pending, sb_empty, mem_req;
  logic [2:0]  spec_cnt;
  logic [3:0]  commit_cnt;
  logic [55:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic [1:0]  mem_size;

  int checks   = 0;
  int failures = 0;

  store_buffer_merge dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .stall_st_pending_i   (stall),
    .valid_i              (valid),
    .valid_without_flush_i(valid_wf),
    .paddr_i              (paddr),
    .data_i               (data),
    .be_i                 (be),
    .data_size_i          (size),
    .ready_o              (ready),
    .commit_i             (commit),
    .commit_ready_o       (commit_ready),
    .page_offset_i        (page_offset),
    .page_offset_matches_o(match),
    .no_st_pending_o      (no_st_pending),
    .store_buffer_empty_o (sb_empty),
    .spec_cnt_o           (spec_cnt),
    .commit_cnt_o         (commit_cnt),
    .mem_req_o            (mem_req),
    .mem_gnt_i            (gnt),
    .mem_addr_o           (mem_addr),
    .mem_wdata_o          (mem_wdata),
    .mem_be_o             (mem_be),
    .mem_size_o           (mem_size)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] b,
                      input logic [1:0] s);
    valid = 1'b1; paddr = a; data = d; be = b; size = s;
    tick();
    valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic drain(input string tag);
    stall = 1'b0;
    gnt   = 1'b1;
    for (int i = 0; i < 12 && !no_st_pending; i++) tick();
    gnt   = 1'b0;
    check(tag, {63'd0, no_st_pending}, 64'd1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 1'b0; valid = 1'b0; valid_wf = 1'b0;
    commit = 1'b0; gnt = 1'b0; paddr = '0; data = '0; be = '0; size = '0;
    page_offset = '0;
    #1 rst = 1'b1;

    // reset state
    tick(); tick();
    check("rst_ready",        {63'd0, ready},         64'd1);
    check("rst_commit_ready", {63'd0, commit_ready},  64'd1);
    check("rst_no_pending",   {63'd0, no_st_pending}, 64'd1);
    check("rst_empty",        {63'd0, sb_empty},      64'd1);
    check("rst_mem_req",      {63'd0, mem_req},       64'd0);
    check("rst_match",        {63'd0, match},         64'd0);
    check("rst_spec_cnt",     {61'd0, spec_cnt},      64'd0);
    check("rst_commit_cnt",   {60'd0, commit_cnt},    64'd0);
    rst = 1'b0;
    tick();

    // in-order drain with grant withheld, then granted
    push(56'h1000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'd3);
    push(56'h1008, 64'hFEDC_BA98_7654_3210, 8'hFF, 2'd3);
    check("push2_spec_cnt",   {61'd0, spec_cnt},      64'd2);
    check("push2_no_pending", {63'd0, no_st_pending}, 64'd1);
    check("push2_empty",      {63'd0, sb_empty},      64'd0);
    do_commit();
    do_commit();
    check("cm2_spec_cnt",   {61'd0, spec_cnt},   64'd0);
    check("cm2_commit_cnt", {60'd0, commit_cnt}, 64'd2);
    check("cm2_mem_req",    {63'd0, mem_req},    64'd1);
    check("cm2_addr",       {8'd0, mem_addr},    64'h1000);
    check("cm2_wdata",      mem_wdata,           64'h0123_4567_89AB_CDEF);
    tick();
    check("hold_addr",      {8'd0, mem_addr},    64'h1000);
    gnt = 1'b1;
    tick();
    check("gnt1_addr",      {8'd0, mem_addr},    64'h1008);
    check("gnt1_wdata",     mem_wdata,           64'hFEDC_BA98_7654_3210);
    check("gnt1_commit_cnt",{60'd0, commit_cnt}, 64'd1);
    tick();
    gnt = 1'b0;
    check("gnt2_mem_req",   {63'd0, mem_req},    64'd0);
    check("gnt2_empty",     {63'd0, sb_empty},   64'd1);

    // ready boundary, flush overriding a push, committed entry survives flush
    push(56'h3000, 64'h33, 8'h01, 2'd0);
    push(56'h3008, 64'h44, 8'h01, 2'd0);
    push(56'h3010, 64'h55, 8'h01, 2'd0);
    check("spec3_cnt",   {61'd0, spec_cnt}, 64'd3);
    check("spec3_ready", {63'd0, ready},    64'd0);
    stall  = 1'b1;
    commit = 1'b1;
    #1;
    check("spec3_ready_commit", {63'd0, ready}, 64'd1);
    tick();
    commit = 1'b0;
    check("stall_mem_req", {63'd0, mem_req}, 64'd0);
    flush = 1'b1;
    push(56'h3018, 64'h66, 8'h01, 2'd0);
    flush = 1'b0;
    check("flush_spec_cnt",   {61'd0, spec_cnt},   64'd0);
    check("flush_ready",      {63'd0, ready},      64'd1);
    check("flush_commit_cnt", {60'd0, commit_cnt}, 64'd1);
    stall = 1'b0;
    #1;
    check("flush_mem_req",  {63'd0, mem_req},  64'd1);
    check("flush_mem_addr", {8'd0, mem_addr},  64'h3000);
    drain("flush_drain");

    // page-offset hazard
    push(56'h5100, 64'h77, 8'hFF, 2'd3);
    page_offset = 12'h104;
    #1;
    check("haz_hit", {63'd0, match}, 64'd1);
    page_offset = 12'h110;
    #1;
    check("haz_miss", {63'd0, match}, 64'd0);
    page_offset = 12'h104;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("haz_after_flush", {63'd0, match}, 64'd0);
    valid_wf = 1'b1; paddr = 56'h7108; page_offset = 12'h10C;
    #1;
    check("haz_incoming", {63'd0, match}, 64'd1);
    valid_wf = 1'b0; page_offset = '0;

    // coalescing into a stalled tail
    stall = 1'b1;
    push(56'h2000, 64'h0000_0000_1122_3344, 8'h0F, 2'd2);
    push(56'h2004, 64'hAABB_CCDD_0000_0000, 8'hF0, 2'd2);
    do_commit();
    do_commit();
`ifdef STORE_BUF_MERGE_EN
    check("mrg_commit_cnt", {60'd0, commit_cnt}, 64'd1);
    check("mrg_be",         {56'd0, mem_be},     64'hFF);
    check("mrg_wdata",      mem_wdata,           64'hAABB_CCDD_1122_3344);
    check("mrg_size",       {62'd0, mem_size},   64'd3);
`else
    check("mrg_commit_cnt", {60'd0, commit_cnt}, 64'd2);
    check("mrg_be",         {56'd0, mem_be},     64'h0F);
    check("mrg_wdata",      mem_wdata,           64'h0000_0000_1122_3344);
    check("mrg_size",       {62'd0, mem_size},   64'd2);
`endif
    check("mrg_addr",    {8'd0, mem_addr}, 64'h2000);
    check("mrg_mem_req", {63'd0, mem_req}, 64'd0);
    drain("mrg_drain");

    // same word but the tail is the head being requested: no merge
    push(56'h2800, 64'h0000_0000_5566_7788, 8'h0F, 2'd2);
    push(56'h2804, 64'h99AA_BBCC_0000_0000, 8'hF0, 2'd2);
    do_commit();
    do_commit();
    check("head_commit_cnt", {60'd0, commit_cnt}, 64'd2);
    check("head_addr",       {8'd0, mem_addr},    64'h2800);
    check("head_be",         {56'd0, mem_be},     64'h0F);
    drain("head_drain");

    // reset while a request is outstanding
    push(56'h4000, 64'h99, 8'hFF, 2'd3);
    do_commit();
    check("mid_mem_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_req",    {63'd0, mem_req},    64'd0);
    check("mid_rst_commit_cnt", {60'd0, commit_cnt}, 64'd0);
    check("mid_rst_empty",      {63'd0, sb_empty},   64'd1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
